// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write
// ports (B has priority over A), optional same-cycle write-to-read bypass,
// and a per-register busy scoreboard tracking outstanding loads.
//
// Handshake note: this block has no valid/ready pairs. A write or mark is
// taken on every rising edge its enable is high; reads are pure
// combinational lookups with no acceptance condition.
module regfile_mp #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we_a,
  input  logic [AW-1:0]                wa_a,
  input  logic [DATA_WIDTH-1:0]        wd_a,
  input  logic                         we_b,
  input  logic [AW-1:0]                wa_b,
  input  logic [DATA_WIDTH-1:0]        wd_b,
  input  logic                         mark_en,
  input  logic [AW-1:0]                mark_addr,
  input  logic [NUM_RD*AW-1:0]         ra,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd,
  output logic [NUM_RD-1:0]            rbusy,
  output logic [NUM_REGS-1:0]          busy_vec,
  output logic                         collision,
  output logic                         mark_err
);

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];
  logic [NUM_REGS-1:0]   r_busy;
  logic                  r_collision;
  logic                  r_mark_err;

  // Enables are masked while reset is held so that discarded writes are
  // not forwarded through the bypass path either.
  logic w_we_a, w_we_b, w_mark;
  logic w_wr_a, w_wr_b;
  logic w_collide;
  logic [NUM_REGS-1:0] w_set, w_clr, w_busy_nxt;
  logic w_mark_err_nxt;

  assign w_we_a = we_a & ~rst;
  assign w_we_b = we_b & ~rst;
  assign w_mark = mark_en & ~rst;

  // With a hardwired r0, writes aimed at r0 never reach the array.
  assign w_wr_a = w_we_a & ~((ZERO_REG != 0) && (wa_a == '0));
  assign w_wr_b = w_we_b & ~((ZERO_REG != 0) && (wa_b == '0));

  // A same-address double write only counts as a collision if both land.
  assign w_collide = w_wr_a & w_wr_b & (wa_a == wa_b);

  // Register array update; port B is written last so it wins on a clash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) r_mem[r] <= '0;
    end else begin
      if (w_wr_a) r_mem[wa_a] <= wd_a;
      if (w_wr_b) r_mem[wa_b] <= wd_b;
    end
  end

  // Scoreboard next state: a new mark beats a same-cycle load return.
  always_comb begin
    w_set          = '0;
    w_clr          = '0;
    w_busy_nxt     = r_busy;
    w_mark_err_nxt = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_set[r] = w_mark & (mark_addr == AW'(r)) & ~((ZERO_REG != 0) && (r == 0));
      w_clr[r] = w_we_b & (wa_b == AW'(r));
      if (w_set[r])      w_busy_nxt[r] = 1'b1;
      else if (w_clr[r]) w_busy_nxt[r] = 1'b0;
      if (w_set[r] && r_busy[r] && !w_clr[r]) w_mark_err_nxt = 1'b1;
    end
  end

  // Scoreboard and single-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= '0;
      r_collision <= 1'b0;
      r_mark_err  <= 1'b0;
    end else begin
      r_busy      <= w_busy_nxt;
      r_collision <= w_collide;
      r_mark_err  <= w_mark_err_nxt;
    end
  end

  assign busy_vec  = r_busy;
  assign collision = r_collision;
  assign mark_err  = r_mark_err;

  // Independent read ports: zero register, then port B, then port A, then array.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0]         w_ra;
    logic                  w_zero;
    logic                  w_hit_a;
    logic                  w_hit_b;
    logic [DATA_WIDTH-1:0] w_data;

    assign w_ra    = ra[gi*AW +: AW];
    assign w_zero  = (ZERO_REG != 0) && (w_ra == '0);
    assign w_hit_b = (BYPASS != 0) && w_we_b && (wa_b == w_ra);
    assign w_hit_a = (BYPASS != 0) && w_we_a && (wa_a == w_ra);
    assign w_data  = w_zero  ? '0   :
                     w_hit_b ? wd_b :
                     w_hit_a ? wd_a : r_mem[w_ra];

    assign rd[gi*DATA_WIDTH +: DATA_WIDTH] = w_data;
    // A load returning this cycle already satisfies the reader.
    assign rbusy[gi] = ~w_zero & r_busy[w_ra] & ~w_hit_b;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (default parameters: BYPASS=1, ZERO_REG=1).
// Stimulus pushes expected observations tagged with the cycle they are due;
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_mp;

  localparam int W  = 16;
  localparam int AW = 4;

  // Observation selectors
  localparam int S_RD0 = 0, S_RD1 = 1, S_RBUSY = 2, S_BUSY = 3, S_COLL = 4, S_MERR = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we_a = 0, we_b = 0, mark_en = 0;
  logic [AW-1:0] wa_a = 0, wa_b = 0, mark_addr = 0;
  logic [W-1:0]  wd_a = 0, wd_b = 0;
  logic [2*AW-1:0] ra = 0;
  logic [2*W-1:0]  rd;
  logic [1:0]      rbusy;
  logic [15:0]     busy_vec;
  logic            collision, mark_err;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int           sel_q[$];
  int           cyc_q[$];

  regfile_mp dut (
    .clk(clk), .rst(rst),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .mark_en(mark_en), .mark_addr(mark_addr),
    .ra(ra), .rd(rd), .rbusy(rbusy), .busy_vec(busy_vec),
    .collision(collision), .mark_err(mark_err)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a_en, input int a_ad, input logic [W-1:0] a_d,
                       input logic b_en, input int b_ad, input logic [W-1:0] b_d,
                       input logic m_en, input int m_ad, input int r0, input int r1);
    we_a = a_en; wa_a = AW'(a_ad); wd_a = a_d;
    we_b = b_en; wa_b = AW'(b_ad); wd_b = b_d;
    mark_en = m_en; mark_addr = AW'(m_ad);
    ra = {AW'(r1), AW'(r0)};
  endtask

  task automatic idle(input int r0, input int r1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  // Expect `val` on selector `sel`, `ofs` cycles from now (0 or 1).
  task automatic expect_at(input int ofs, input int sel, input logic [W-1:0] val);
    cyc_q.push_back(cyc + ofs);
    sel_q.push_back(sel);
    exp_q.push_back(val);
  endtask

  function automatic string sel_name(input int s);
    case (s)
      S_RD0:   return "rd0";
      S_RD1:   return "rd1";
      S_RBUSY: return "rbusy";
      S_BUSY:  return "busy_vec";
      S_COLL:  return "collision";
      default: return "mark_err";
    endcase
  endfunction

  function automatic logic [W-1:0] observe(input int s);
    case (s)
      S_RD0:   return rd[W-1:0];
      S_RD1:   return rd[2*W-1:W];
      S_RBUSY: return {14'd0, rbusy};
      S_BUSY:  return busy_vec;
      S_COLL:  return {15'd0, collision};
      default: return {15'd0, mark_err};
    endcase
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
      int           c;
      int           s;
      logic [W-1:0] e;
      logic [W-1:0] act;
      c = cyc_q.pop_front();
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (c < cyc) begin
        errors++;
        $display("FAIL %s cycle %0d: observation missed (now cycle %0d)", sel_name(s), c, cyc);
      end else begin
        act = observe(s);
        if (act !== e) begin
          errors++;
          $display("FAIL %s cycle %0d: got %h expected %h", sel_name(s), c, act, e);
        end
      end
    end
  end

  initial begin
    // Held in reset
    idle(0, 0);
    tick();
    expect_at(0, S_RD0, 16'h0); expect_at(0, S_BUSY, 16'h0);
    expect_at(0, S_COLL, 16'h0); expect_at(0, S_MERR, 16'h0);
    tick();
    rst = 1'b0;

    // Write r3 and mark r5, then reset asynchronously
    tick();
    drive(1, 3, 16'h1234, 0, 0, 0, 1, 5, 3, 5);
    expect_at(0, S_RD0, 16'h1234); expect_at(0, S_RBUSY, 16'h0);
    tick();
    idle(3, 5);
    expect_at(0, S_RD0, 16'h1234); expect_at(0, S_BUSY, 16'h0020);
    expect_at(0, S_RBUSY, 16'h0002);
    tick();
    idle(3, 5);
    rst = 1'b1;
    expect_at(0, S_RD0, 16'h0); expect_at(0, S_RD1, 16'h0);
    expect_at(0, S_BUSY, 16'h0); expect_at(0, S_COLL, 16'h0); expect_at(0, S_RBUSY, 16'h0);
    tick();
    // Writes and marks during reset are discarded and not bypassed
    drive(1, 3, 16'hFFFF, 0, 0, 0, 1, 5, 3, 5);
    expect_at(0, S_RD0, 16'h0); expect_at(0, S_RBUSY, 16'h0);
    tick();
    rst = 1'b0;
    idle(3, 5);
    expect_at(0, S_RD0, 16'h0); expect_at(0, S_BUSY, 16'h0);

    // Basic write/read and zero register
    tick();
    drive(1, 3, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 16'h5555, 0, 0, 0, 0, 0, 3, 0);
    expect_at(0, S_RD0, 16'hBEEF); expect_at(0, S_RD1, 16'h0);
    tick();
    idle(3, 0);
    expect_at(0, S_RD0, 16'hBEEF); expect_at(0, S_RD1, 16'h0);

    // Same-cycle bypass
    tick();
    drive(1, 7, 16'h00AA, 0, 0, 0, 0, 0, 7, 7);
    expect_at(0, S_RD0, 16'h00AA); expect_at(0, S_RD1, 16'h00AA);
    tick();
    idle(7, 3);
    expect_at(0, S_RD0, 16'h00AA); expect_at(0, S_RD1, 16'hBEEF);

    // Collision: port B wins, one-cycle pulse
    tick();
    drive(1, 4, 16'h1111, 1, 4, 16'h2222, 0, 0, 4, 4);
    expect_at(0, S_RD0, 16'h2222); expect_at(0, S_COLL, 16'h0);
    expect_at(1, S_COLL, 16'h1);
    tick();
    idle(4, 0);
    expect_at(0, S_RD0, 16'h2222); expect_at(1, S_COLL, 16'h0);
    tick();
    // Double write to r0 is not a collision
    drive(1, 0, 16'h1111, 1, 0, 16'h2222, 0, 0, 0, 4);
    expect_at(0, S_RD0, 16'h0); expect_at(1, S_COLL, 16'h0);

    // Scoreboard: mark, re-mark error, load return clears
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 6, 6, 0);
    expect_at(0, S_RBUSY, 16'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 6, 6, 6);
    expect_at(0, S_BUSY, 16'h0040); expect_at(0, S_RBUSY, 16'h0003);
    expect_at(0, S_MERR, 16'h0); expect_at(1, S_MERR, 16'h1);
    tick();
    idle(6, 0);
    expect_at(0, S_BUSY, 16'h0040); expect_at(1, S_MERR, 16'h0);
    tick();
    drive(0, 0, 0, 1, 6, 16'h0F0F, 0, 0, 6, 6);
    expect_at(0, S_RBUSY, 16'h0); expect_at(0, S_RD0, 16'h0F0F);
    expect_at(0, S_RD1, 16'h0F0F); expect_at(0, S_BUSY, 16'h0040);
    tick();
    idle(6, 0);
    expect_at(0, S_BUSY, 16'h0); expect_at(0, S_RD0, 16'h0F0F); expect_at(0, S_RBUSY, 16'h0);

    // Mark and load return on the same register in one cycle
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 6, 6, 0);
    tick();
    drive(0, 0, 0, 1, 6, 16'h5A5A, 1, 6, 6, 0);
    expect_at(0, S_BUSY, 16'h0040); expect_at(0, S_RD0, 16'h5A5A);
    expect_at(0, S_RBUSY, 16'h0); expect_at(1, S_MERR, 16'h0);
    tick();
    // Marks to r0 are ignored
    drive(0, 0, 0, 0, 0, 0, 1, 0, 6, 0);
    expect_at(0, S_BUSY, 16'h0040); expect_at(0, S_RD0, 16'h5A5A);
    expect_at(0, S_RBUSY, 16'h0001);
    tick();
    idle(6, 0);
    expect_at(0, S_BUSY, 16'h0040); expect_at(0, S_MERR, 16'h0);

    // Drain and final report
    tick();
    idle(0, 0);
    tick();
    tick();
    while (cyc_q.size() > 0) begin
      int c;
      int s;
      c = cyc_q.pop_front();
      s = sel_q.pop_front();
      void'(exp_q.pop_front());
      checks++;
      errors++;
      $display("FAIL %s cycle %0d: observation never made", sel_name(s), c);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
